// File: rtl/fpas_arbiter_if.sv
`default_nettype none
// ============================================================================
// fpas_arbiter_if : requester, response and FP-unit signal bundle
// Revision 1.0
// ============================================================================
interface fpas_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_op;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_result;
  logic [IDW-1:0]     resp_id;
  logic               unit_start;
  logic [31:0]        unit_a;
  logic [31:0]        unit_b;
  logic               unit_op;
  logic [31:0]        unit_result;

  // slave = arbiter side, master = requesters, consumer and FP unit
  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready, unit_result,
    output req_ready, resp_valid, resp_result, resp_id,
           unit_start, unit_a, unit_b, unit_op
  );
  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready, unit_result,
    input  req_ready, resp_valid, resp_result, resp_id,
           unit_start, unit_a, unit_b, unit_op
  );
endinterface
`default_nettype wire

// File: rtl/fpas_arbiter.sv
`default_nettype none
// ============================================================================
// fpas_arbiter : round-robin sequencer sharing one multi-cycle FP add/sub unit
// Revision 1.0
// ============================================================================
module fpas_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fpas_arbiter_if.slave bus,
  output logic          busy,
  output logic [15:0]   op_count
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic            op_q, op_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_result_q, resp_result_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [15:0]     op_count_q, op_count_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic            grant;

  // Rotating priority scan starting at rr_ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign grant = (state_q == S_IDLE) && found && (!resp_valid_q || bus.resp_ready);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_id_d     = resp_id_q;
    op_count_d    = op_count_q;

    if (resp_valid_q && bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          a_d      = bus.req_a[32*int'(win) +: 32];
          b_d      = bus.req_b[32*int'(win) +: 32];
          op_d     = bus.req_op[win];
          id_d     = win;
          rr_ptr_d = IDW'((int'(win) + 1) % NREQ);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CAPTURE: begin
        resp_valid_d  = 1'b1;
        resp_result_d = bus.unit_result;
        resp_id_d     = id_q;
        op_count_d    = op_count_q + 16'd1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= 1'b0;
      id_q          <= '0;
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_id_q     <= resp_id_d;
      op_count_q    <= op_count_d;
    end
  end

  assign bus.req_ready   = grant ? (NREQ'(1) << win) : '0;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.unit_start  = (state_q == S_ISSUE);
  assign bus.unit_a      = a_q;
  assign bus.unit_b      = b_q;
  assign bus.unit_op     = op_q;
  assign busy            = (state_q != S_IDLE);
  assign op_count        = op_count_q;
endmodule
`default_nettype wire

// File: doc/fpas_arbiter.md
Name: fpas_arbiter

Overview:
Sequencer and round-robin arbiter that shares one multi-cycle FP add/sub unit between NREQ requesters. It accepts one operation at a time through per-requester valid/ready handshakes. It drives the unit's start, operands and opcode, and times the unit's fixed latency. It captures the unit result into a one-entry response register tagged with the requester index.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; NREQ <= 2^IDW
LAT, 4, number of clocks from the edge at which the unit samples start to the edge at which its result register is written

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; the same rst also resets the FP unit at top level
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*32  flattened IEEE-754 single operand A; requester i occupies bits [32i+31:32i]
req_b  in  NREQ*32  flattened operand B, same packing as req_a
req_op  in  NREQ  per-requester opcode (0 = add, 1 = sub)
resp_valid  out  1  response register holds a result
resp_ready  in  1  consumer accepts response
resp_result  out  32  IEEE-754 result
resp_id  out  IDW  index of the requester that issued the operation
unit_start  out  1  start pulse to the FP unit
unit_a  out  32  operand A to the unit
unit_b  out  32  operand B to the unit
unit_op  out  1  opcode to the unit
unit_result  in  32  registered result from the unit
busy  out  1  high in any state other than IDLE
op_count  out  16  completed-operation counter

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE, rr_ptr=0, resp_valid=0, resp_result=0, resp_id=0, op_count=0.
  - Operand, opcode and index holding registers are cleared to 0; unit_start=0.
  - An in-flight operation is dropped and no response is produced.
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE, grant condition: at least one req_valid is high AND (resp_valid==0 OR resp_ready==1).
- IDLE, when granting:
  - Winner = first i with req_valid[i]==1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner]=1 combinationally in that cycle only.
  - At the edge, latch req_a/req_b/req_op of the winner and its index, set rr_ptr=(winner+1) mod NREQ, go to ISSUE.
- req_ready is 0 for every requester in ISSUE, WAIT and CAPTURE, and in IDLE when the grant condition is false.
- ISSUE: unit_start=1 for exactly this one cycle. Load wait counter with LAT-1. Go to WAIT.
- WAIT: unit_start=0. The counter decrements each cycle; when the counter is 0, go to CAPTURE. WAIT lasts exactly LAT cycles.
- CAPTURE: unit_result is valid. At the edge: resp_result<=unit_result, resp_id<=latched index, resp_valid<=1, op_count<=op_count+1 (wraps 0xFFFF->0x0000), go to IDLE.
- unit_a, unit_b and unit_op are driven from the holding registers and stay stable from ISSUE through CAPTURE.
- Latency: grant at edge T -> resp_valid=1 after edge T+LAT+2 (6 clocks at default).
- Throughput: 1 operation per LAT+3 clocks without backpressure.
- Response handshake: resp_valid drops at an edge where resp_ready=1 and no new capture occurs.
  - CAPTURE can only follow a grant made with the register empty or draining, so overwrite never occurs.
  - resp_result and resp_id hold while resp_valid=1 and resp_ready=0.
- Simultaneous events:
  - Response accept and new grant in the same IDLE cycle are both performed.
  - A requester dropping req_valid while not granted loses nothing.
  - req_ready is never asserted without req_valid.
- No grant while the unit is busy, so the unit never sees start outside its idle state.
- busy=1 in ISSUE, WAIT and CAPTURE.

Test Plan:
- Single add: requester 0 sends a=0x3F800000, b=0x40000000, op=0, resp_ready=1 -> req_ready[0] pulses once, unit_start pulses 1 cycle later, resp_valid after 6 clocks with resp_result=0x40400000, resp_id=0, op_count=1.
- Single sub: requester 2 sends a=0x40400000, b=0x3F800000, op=1 -> resp_result=0x40000000, resp_id=2.
- Fairness: all 4 requesters hold req_valid continuously from reset -> grants in order 0,1,2,3,0,1; one unit_start every 7 clocks; no requester granted twice before the others.
- Backpressure: resp_ready=0 with two pending requests -> first response held stable; no second req_ready, unit_start stays 0; raising resp_ready produces the second grant in that same cycle.
- Reset mid-op: rst asserted during WAIT -> next cycle state is IDLE, resp_valid=0, op_count=0, rr_ptr=0; no response ever appears for the dropped operation.
- Counter wrap: force 65536 completions (or preload in simulation) -> op_count returns to 0x0000.
